reg_watch_checker: RTL and testbench

//  Self-checking register-writeback monitor for the pipelined processor.

---
 rtl/reg_watch_checker_pkg.sv | 11 +
 rtl/reg_watch_checker_slot.sv | 49 ++++
 rtl/reg_watch_checker.sv | 119 +++++++++++
 tb/tb_reg_watch_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_watch_checker_pkg.sv
// Shared types for the register-writeback watch checker.
package reg_watch_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_watch_checker_slot.sv
// One watched register: latched address/expected value plus a live shadow copy.
module watch_slot
    import reg_watch_checker_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr_init,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] exp_init,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] shadow,
    output logic              eq,
    output logic              eq_next
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] shadow_q;
    logic              hit;
    logic [DATA_W-1:0] post_write;

    assign hit        = wr_en && (addr_q == wb_addr);
    assign post_write = hit ? wb_data : shadow_q;
    assign shadow     = shadow_q;
    assign eq         = (shadow_q == exp_q);
    // Equality as it will stand after this cycle's write, for early finish.
    assign eq_next    = (post_write == exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            exp_q    <= '0;
            shadow_q <= '0;
        end else if (load) begin
            addr_q   <= addr_init;
            exp_q    <= exp_init;
            shadow_q <= init_data;
        end else begin
            shadow_q <= post_write;
        end
    end

endmodule

// File: rtl/reg_watch_checker.sv
// Writeback snooper: shadows watched registers over a fixed run, then reports pass/fail.
module reg_watch_checker
    import reg_watch_checker_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_WATCH  = 3,
    parameter int CYC_W      = 8,
    parameter int MAX_CYCLES = 6,
    parameter int EARLY_PASS = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
    input  logic [NUM_WATCH*DATA_W-1:0] init_data,
    input  logic [NUM_WATCH*DATA_W-1:0] exp_data,
    input  logic                        wb_en,
    input  logic [ADDR_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]           wb_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic [NUM_WATCH-1:0]        mismatch,
    output logic [CYC_W-1:0]            cycle_count,
    output logic [NUM_WATCH*DATA_W-1:0] shadow_data
);

    localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);

    state_t               state_q, state_d;
    logic [CYC_W-1:0]     cnt_q;
    logic                 pass_q, fail_q;
    logic [NUM_WATCH-1:0] mism_q;
    logic [NUM_WATCH-1:0] eq, eq_next;
    logic                 load, wr, last, early_hit;

    assign load      = start && !abort && (state_q == IDLE || state_q == DONE);
    assign wr        = (state_q == RUN) && !abort && wb_en && (wb_addr != '0);
    assign last      = (cnt_q == MAX_C);
    assign early_hit = (EARLY_PASS != 0) && (&eq_next);

    for (genvar i = 0; i < NUM_WATCH; i++) begin : g_slot
        watch_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .wr_en     (wr),
            .addr_init (watch_addr[i*ADDR_W +: ADDR_W]),
            .init_data (init_data[i*DATA_W +: DATA_W]),
            .exp_init  (exp_data[i*DATA_W +: DATA_W]),
            .wb_addr   (wb_addr),
            .wb_data   (wb_data),
            .shadow    (shadow_data[i*DATA_W +: DATA_W]),
            .eq        (eq[i]),
            .eq_next   (eq_next[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
                if (early_hit)  state_d = DONE;
                else if (last)  state_d = CHECK;
            end
            CHECK:              state_d = DONE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            mism_q <= '0;
        end else if (abort) begin
            cnt_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            mism_q <= '0;
        end else if (load) begin
            cnt_q  <= CYC_W'(1);
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            mism_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (early_hit)  pass_q <= 1'b1;
                    else if (!last) cnt_q  <= cnt_q + CYC_W'(1);
                end
                CHECK: begin
                    mism_q <= ~eq;
                    pass_q <= &eq;
                    fail_q <= ~&eq;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q == RUN) || (state_q == CHECK);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign mismatch    = mism_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_reg_watch_checker.sv
// Bench: two checkers (normal and early-pass) on one stimulus bus, scored against a run-level model.
module tb_reg_watch_checker;

    localparam int DW = 32, AW = 5, NW = 3, CW = 8, MAXC = 6;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NW*AW-1:0] watch_addr = '0;
    logic [NW*DW-1:0] init_data = '0, exp_data = '0;
    logic wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;

    logic busy0, done0, pass0, fail0, busy1, done1, pass1, fail1;
    logic [NW-1:0] mism0, mism1;
    logic [CW-1:0] cnt0, cnt1;
    logic [NW*DW-1:0] sh0, sh1;

    int checks = 0, errors = 0;

    // Run description consumed by drive_run and the model
    logic [NW*AW-1:0] cfg_addr;
    logic [NW*DW-1:0] cfg_init, cfg_exp;
    bit               w_en   [0:MAXC];
    logic [AW-1:0]    w_addr [0:MAXC];
    logic [DW-1:0]    w_data [0:MAXC];
    bit               w_start[0:MAXC];
    logic             busy_at_check, done_at_check;

    always #5 clk = ~clk;

    reg_watch_checker #(.DATA_W(DW), .ADDR_W(AW), .NUM_WATCH(NW), .CYC_W(CW),
                        .MAX_CYCLES(MAXC), .EARLY_PASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .watch_addr(watch_addr), .init_data(init_data), .exp_data(exp_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0),
        .mismatch(mism0), .cycle_count(cnt0), .shadow_data(sh0));

    reg_watch_checker #(.DATA_W(DW), .ADDR_W(AW), .NUM_WATCH(NW), .CYC_W(CW),
                        .MAX_CYCLES(MAXC), .EARLY_PASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .watch_addr(watch_addr), .init_data(init_data), .exp_data(exp_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
        .mismatch(mism1), .cycle_count(cnt1), .shadow_data(sh1));

    task automatic clear_writes();
        for (int c = 0; c <= MAXC; c++) begin
            w_en[c] = 1'b0; w_addr[c] = '0; w_data[c] = '0; w_start[c] = 1'b0;
        end
    endtask

    task automatic set_sub_cfg();
        cfg_addr = {5'd8, 5'd9, 5'd10};
        cfg_init = {32'd3, 32'd5, 32'd0};
        cfg_exp  = {32'd3, 32'd5, 32'd2};
    endtask

    // Whole-run model: replay the writes onto the slot values, then compare to expected.
    task automatic model(input bit ep, output logic [NW*DW-1:0] sh, output logic [NW-1:0] mm,
                         output int endc, output bit early);
        sh = cfg_init; mm = '0; endc = MAXC; early = 1'b0;
        for (int c = 1; c <= MAXC; c++) begin
            if (w_en[c] && w_addr[c] != 0)
                for (int i = 0; i < NW; i++)
                    if (cfg_addr[i*AW +: AW] == w_addr[c]) sh[i*DW +: DW] = w_data[c];
            if (ep && sh == cfg_exp) begin
                early = 1'b1; endc = c;
                return;
            end
        end
        for (int i = 0; i < NW; i++) mm[i] = (sh[i*DW +: DW] != cfg_exp[i*DW +: DW]);
    endtask

    // Entered at a negedge with the checker idle or done; leaves at the negedge in DONE.
    // The CHECK cycle carries a write to slot0 that must be ignored.
    task automatic drive_run();
        start = 1'b1; watch_addr = cfg_addr; init_data = cfg_init; exp_data = cfg_exp; wb_en = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= MAXC; c++) begin
            start = w_start[c]; wb_en = w_en[c]; wb_addr = w_addr[c]; wb_data = w_data[c];
            @(negedge clk);
        end
        start = 1'b0; busy_at_check = busy0; done_at_check = done0;
        wb_en = 1'b1; wb_addr = cfg_addr[AW-1:0]; wb_data = 32'hDEAD_BEEF;
        if (wb_addr == 0) wb_addr = 5'd1;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy0, done0, pass0, fail0, mism0, cnt0, sh0} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b pass=%b fail=%b mm=%b cnt=%0d sh=%h want all zero",
                               busy0, done0, pass0, fail0, mism0, cnt0, sh0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy0, done0);
        end
    endtask

    task automatic test_sub_pass();
        set_sub_cfg(); clear_writes();
        w_en[4] = 1'b1; w_addr[4] = 5'd10; w_data[4] = 32'd2;
        drive_run();
        checks++;
        if (busy_at_check !== 1'b1 || done_at_check !== 1'b0) begin
            errors++; $display("FAIL sub_pass_check_phase got busy=%b done=%b want 1 0", busy_at_check, done_at_check);
        end
        checks++;
        if ({done0, pass0, fail0, mism0, cnt0} !== {1'b1, 1'b1, 1'b0, 3'b000, 8'd6}) begin
            errors++; $display("FAIL sub_pass got done=%b pass=%b fail=%b mm=%b cnt=%0d want 1 1 0 000 6",
                               done0, pass0, fail0, mism0, cnt0);
        end
        checks++;
        if (sh0 !== {32'd3, 32'd5, 32'd2}) begin
            errors++; $display("FAIL sub_pass_shadow got %h want %h", sh0, {32'd3, 32'd5, 32'd2});
        end
        checks++;
        if ({done1, pass1, cnt1} !== {1'b1, 1'b1, 8'd4}) begin
            errors++; $display("FAIL sub_pass_early got done=%b pass=%b cnt=%0d want 1 1 4", done1, pass1, cnt1);
        end
    endtask

    task automatic test_sub_fail();
        set_sub_cfg(); clear_writes();
        w_en[4] = 1'b1; w_addr[4] = 5'd10; w_data[4] = 32'd7;
        drive_run();
        checks++;
        if ({done0, pass0, fail0, mism0, cnt0} !== {1'b1, 1'b0, 1'b1, 3'b001, 8'd6}) begin
            errors++; $display("FAIL sub_fail got done=%b pass=%b fail=%b mm=%b cnt=%0d want 1 0 1 001 6",
                               done0, pass0, fail0, mism0, cnt0);
        end
    endtask

    task automatic test_addr_zero();
        cfg_addr = {5'd8, 5'd9, 5'd0};
        cfg_init = {32'd3, 32'd5, 32'd0};
        cfg_exp  = cfg_init;
        clear_writes();
        w_en[2] = 1'b1; w_addr[2] = 5'd0; w_data[2] = 32'hFFFF_FFFF;
        drive_run();
        checks++;
        if (sh0 !== cfg_init || pass0 !== 1'b1 || mism0 !== 3'b000) begin
            errors++; $display("FAIL addr_zero got sh=%h pass=%b mm=%b want sh=%h pass=1 mm=000", sh0, pass0, mism0, cfg_init);
        end
    endtask

    task automatic test_early_pass();
        set_sub_cfg();
        start = 1'b1; watch_addr = cfg_addr; init_data = cfg_init; exp_data = cfg_exp;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd2;
        @(negedge clk); wb_en = 1'b0;
        checks++;
        if ({done1, busy1, pass1, fail1, mism1, cnt1} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 8'd2}) begin
            errors++; $display("FAIL early_pass got done=%b busy=%b pass=%b fail=%b mm=%b cnt=%0d want 1 0 1 0 000 2",
                               done1, busy1, pass1, fail1, mism1, cnt1);
        end
        checks++;
        if (busy0 !== 1'b1 || cnt0 !== 8'd3) begin
            errors++; $display("FAIL early_pass_normal got busy=%b cnt=%0d want 1 3", busy0, cnt0);
        end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_abort();
        set_sub_cfg();
        start = 1'b1; watch_addr = cfg_addr; init_data = cfg_init; exp_data = cfg_exp;
        @(negedge clk); start = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd2;
        @(negedge clk); wb_en = 1'b0;
        @(negedge clk);
        abort = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA;
        @(negedge clk); abort = 1'b0; wb_en = 1'b0;
        checks++;
        if ({busy0, done0, pass0, fail0, mism0, cnt0} !== '0) begin
            errors++; $display("FAIL abort_idle got busy=%b done=%b pass=%b fail=%b mm=%b cnt=%0d want all 0",
                               busy0, done0, pass0, fail0, mism0, cnt0);
        end
        checks++;
        if (sh0 !== {32'd3, 32'd5, 32'd2}) begin
            errors++; $display("FAIL abort_shadow_kept got %h want %h", sh0, {32'd3, 32'd5, 32'd2});
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || cnt0 !== 8'd1) begin
            errors++; $display("FAIL abort_restart got busy=%b cnt=%0d want 1 1", busy0, cnt0);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || cnt0 !== 8'd0) begin
            errors++; $display("FAIL abort_beats_start got busy=%b cnt=%0d want 0 0", busy0, cnt0);
        end
    endtask

    task automatic test_async_reset();
        set_sub_cfg();
        start = 1'b1; watch_addr = cfg_addr; init_data = cfg_init; exp_data = cfg_exp;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, pass0, fail0, mism0, cnt0, sh0} !== '0) begin
            errors++; $display("FAIL async_reset got busy=%b cnt=%0d sh=%h want all zero", busy0, cnt0, sh0);
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || cnt0 !== 8'd0) begin
            errors++; $display("FAIL reset_blocks_start got busy=%b cnt=%0d want 0 0", busy0, cnt0);
        end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_last_cycle_write();
        set_sub_cfg();
        cfg_exp = {32'h77, 32'd5, 32'd0};
        clear_writes();
        w_start[3] = 1'b1;
        w_en[MAXC] = 1'b1; w_addr[MAXC] = 5'd8; w_data[MAXC] = 32'h77;
        drive_run();
        checks++;
        if ({done0, pass0, mism0, cnt0} !== {1'b1, 1'b1, 3'b000, 8'd6} || sh0 !== {32'h77, 32'd5, 32'd0}) begin
            errors++; $display("FAIL last_cycle_write got done=%b pass=%b mm=%b cnt=%0d sh=%h want 1 1 000 6 %h",
                               done0, pass0, mism0, cnt0, sh0, {32'h77, 32'd5, 32'd0});
        end
    endtask

    task automatic test_random();
        logic [NW*DW-1:0] sh_f, sh_e;
        logic [NW-1:0]    mm_f, mm_e;
        int               endc_f, endc_e;
        bit               early_f, early_e;
        for (int r = 0; r < 25; r++) begin
            clear_writes();
            for (int i = 0; i < NW; i++) begin
                cfg_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                cfg_init[i*DW +: DW] = DW'($urandom_range(0, 3));
            end
            for (int c = 1; c <= MAXC; c++) begin
                w_en[c]   = 1'($urandom_range(0, 1));
                w_addr[c] = AW'($urandom_range(0, 4));
                w_data[c] = DW'($urandom_range(0, 3));
            end
            cfg_exp = cfg_init;
            model(1'b0, sh_f, mm_f, endc_f, early_f);
            for (int i = 0; i < NW; i++)
                if ($urandom_range(0, 3) == 0) cfg_exp[i*DW +: DW] = DW'($urandom_range(0, 3));
                else                           cfg_exp[i*DW +: DW] = sh_f[i*DW +: DW];
            if (cfg_exp == cfg_init) cfg_exp[0] = ~cfg_exp[0];
            model(1'b0, sh_f, mm_f, endc_f, early_f);
            model(1'b1, sh_e, mm_e, endc_e, early_e);
            drive_run();
            checks++;
            if ({done0, pass0, fail0, mism0, cnt0} !== {1'b1, ~|mm_f, |mm_f, mm_f, CW'(endc_f)} || sh0 !== sh_f) begin
                errors++; $display("FAIL random_%0d got pass=%b fail=%b mm=%b cnt=%0d sh=%h want %b %b %b %0d %h",
                                   r, pass0, fail0, mism0, cnt0, sh0, ~|mm_f, |mm_f, mm_f, endc_f, sh_f);
            end
            checks++;
            if ({done1, pass1, mism1, cnt1} !== {1'b1, early_e | ~|mm_e, mm_e, CW'(endc_e)} || sh1 !== sh_e) begin
                errors++; $display("FAIL random_early_%0d got pass=%b mm=%b cnt=%0d sh=%h want %b %b %0d %h",
                                   r, pass1, mism1, cnt1, sh1, early_e | ~|mm_e, mm_e, endc_e, sh_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_pass();
        test_sub_fail();
        test_addr_zero();
        test_early_pass();
        test_abort();
        test_async_reset();
        test_last_cycle_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
